pc_seq_unit: RTL and testbench

- Parametrised program-counter sequencer for the MIPS fetch stage; generalises the plain 32-bit PC latch.
- Adds reset vector, stall, redirect (branch/jump), and a hardware return-address stack (RAS) for call/return.
- Sits between the branch/jump resolution logic and instruction-memory address input; pc_out drives the I-mem address directly.

---
 rtl/pc_seq_unit.sv | 114 +++++++++++
 tb/tb_pc_seq_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer for the fetch stage: reset vector, stall, redirect and a return-address stack.
// Optional target alignment check and misalign pulse are enabled by defining PC_ALIGN_CHECK_EN.
module pc_seq_unit #(
  parameter int            AW        = 32,
  parameter int            STEP      = 4,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int            RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [AW-1:0]                redirect_target,
  input  logic                         call,
  input  logic                         ret,
  output logic [AW-1:0]                pc_out,
  output logic [AW-1:0]                pc_seq,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_full,
  output logic                         ras_empty,
`ifdef PC_ALIGN_CHECK_EN
  output logic                         misalign,
`endif
  output logic                         ras_underflow
);

  localparam int            PW     = $clog2(RAS_DEPTH);
  localparam int            CW     = PW + 1;
  localparam logic [AW-1:0] STEP_V = AW'(STEP);

  logic [AW-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [AW-1:0] redir_pc;
  logic [AW-1:0] redir_load;
  logic [AW-1:0] pop_load;
  logic          redir_mis;
  logic          pop_mis;
  logic          push_en;

  assign pc_seq    = pc_out + STEP_V;
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);
  assign push_en   = !stall && redirect_valid && call;

  // An undriven redirect target in simulation falls back to the reset vector.
  always_comb begin
    redir_pc = redirect_target;
`ifndef SYNTHESIS
    if ($isunknown(redirect_target)) redir_pc = RESET_VEC;
`endif
  end

  always_comb begin
    redir_load = redir_pc;
    pop_load   = ras[ptr - PW'(1)];
    redir_mis  = 1'b0;
    pop_mis    = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    redir_mis  = (redir_pc[1:0] != 2'b00);
    pop_mis    = (pop_load[1:0] != 2'b00);
    redir_load = {redir_pc[AW-1:2], 2'b00};
    pop_load   = {pop_load[AW-1:2], 2'b00};
`endif
  end

  // Return-address storage needs no reset; a full stack simply overwrites its oldest slot.
  always_ff @(posedge clk) begin
    if (push_en) ras[ptr] <= pc_seq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out        <= RESET_VEC;
      ptr           <= '0;
      ras_count     <= '0;
      ras_underflow <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign      <= 1'b0;
`endif
    end else begin
      ras_underflow <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign      <= 1'b0;
`endif
      if (!stall) begin
        if (redirect_valid) begin
          pc_out <= redir_load;
`ifdef PC_ALIGN_CHECK_EN
          misalign <= redir_mis;
`endif
          if (call) begin
            ptr <= ptr + PW'(1);
            if (!ras_full) ras_count <= ras_count + CW'(1);
          end
        end else if (ret) begin
          if (!ras_empty) begin
            pc_out    <= pop_load;
            ptr       <= ptr - PW'(1);
            ras_count <= ras_count - CW'(1);
`ifdef PC_ALIGN_CHECK_EN
            misalign  <= pop_mis;
`endif
          end else begin
            pc_out        <= RESET_VEC;
            ras_underflow <= 1'b1;
          end
        end else begin
          pc_out <= pc_seq;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: queue-based reference model compared every cycle,
// plus directed literal expectations. Covers PC_ALIGN_CHECK_EN when that macro is defined.
module tb_pc_seq_unit;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        call;
  logic        ret;
  logic [31:0] pc_out;
  logic [31:0] pc_seq;
  logic [2:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        ras_underflow;
  logic        misalign;

  int passed;
  int total;
  bit chk_en;

  pc_seq_unit #(.AW(32), .STEP(4), .RESET_VEC(RV), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .call(call), .ret(ret), .pc_out(pc_out), .pc_seq(pc_seq),
    .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
`ifdef PC_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .ras_underflow(ras_underflow)
  );

`ifndef PC_ALIGN_CHECK_EN
  assign misalign = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stack is a bounded queue whose back is the top.
  logic [31:0] m_pc;
  logic        m_uf;
  logic        m_mis;
  logic [31:0] m_ras[$];
  logic [31:0] m_tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RV; m_uf = 1'b0; m_mis = 1'b0; m_ras.delete();
    end else begin
      m_uf = 1'b0; m_mis = 1'b0;
      if (stall) begin
        m_pc = m_pc;
      end else if (redirect_valid) begin
        if (call) begin
          if (m_ras.size() == 4) void'(m_ras.pop_front());
          m_ras.push_back(m_pc + 32'd4);
        end
        m_tmp = redirect_target;
`ifdef PC_ALIGN_CHECK_EN
        if (m_tmp[1:0] != 2'b00) begin m_mis = 1'b1; m_tmp[1:0] = 2'b00; end
`endif
        m_pc = m_tmp;
      end else if (ret) begin
        if (m_ras.size() > 0) begin
          m_tmp = m_ras.pop_back();
`ifdef PC_ALIGN_CHECK_EN
          if (m_tmp[1:0] != 2'b00) begin m_mis = 1'b1; m_tmp[1:0] = 2'b00; end
`endif
          m_pc = m_tmp;
        end else begin
          m_pc = RV; m_uf = 1'b1;
        end
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Every falling edge the DUT outputs must equal the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model pc_out", pc_out, m_pc);
      checkOutput("model pc_seq", pc_seq, m_pc + 32'd4);
      checkOutput("model ras_count", 32'(ras_count), 32'(m_ras.size()));
      checkOutput("model ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
      checkOutput("model ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      checkOutput("model ras_underflow", 32'(ras_underflow), 32'(m_uf));
      checkOutput("model misalign", 32'(misalign), 32'(m_mis));
    end
  end

  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] tgt,
                               input logic c, input logic r);
    stall = s; redirect_valid = rv; redirect_target = tgt; call = c; ret = r;
    @(posedge clk);
    #1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [31:0] tgt);
    applyStimulus(1'b0, 1'b1, tgt, 1'b0, 1'b0);
  endtask

  task automatic callTo(input logic [31:0] tgt);
    applyStimulus(1'b0, 1'b1, tgt, 1'b1, 1'b0);
  endtask

  task automatic doRet();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    passed = 0; total = 0; chk_en = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0; call = 1'b0; ret = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset pc_out", pc_out, RV);
    checkOutput("reset ras_empty", 32'(ras_empty), 32'd1);
    checkOutput("reset ras_count", 32'(ras_count), 32'd0);
    chk_en = 1'b1;
    #4 rst_n = 1'b1;
    idle(); checkOutput("boot +1", pc_out, 32'h0040_0004);
    idle(); checkOutput("boot +2", pc_out, 32'h0040_0008);
    idle(); checkOutput("boot +3", pc_out, 32'h0040_000C);

    // Asynchronous reset in the middle of a cycle.
    jump(32'h100); checkOutput("pre-reset pc", pc_out, 32'h100);
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset pc", pc_out, RV);
    #2 rst_n = 1'b1;
    idle(); checkOutput("post-reset pc", pc_out, 32'h0040_0004);

    // Stall blocks a simultaneous redirect.
    jump(32'h100);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0); checkOutput("stall 1", pc_out, 32'h100);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0); checkOutput("stall 2", pc_out, 32'h100);
    idle(); checkOutput("unstall", pc_out, 32'h104);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stalled ret no underflow", 32'(ras_underflow), 32'd0);
    checkOutput("stalled ret pc", pc_out, 32'h104);

    // Call and return.
    jump(32'h100);
    callTo(32'h800); checkOutput("call pc", pc_out, 32'h800);
    checkOutput("call count", 32'(ras_count), 32'd1);
    idle(); checkOutput("callee +1", pc_out, 32'h804);
    idle(); checkOutput("callee +2", pc_out, 32'h808);
    doRet(); checkOutput("ret pc", pc_out, 32'h104);
    checkOutput("ret empty", 32'(ras_empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bare call pc", pc_out, 32'h108);
    checkOutput("bare call count", 32'(ras_count), 32'd0);

    // Five nested calls overflow a 4-deep stack.
    jump(32'h10);
    for (int i = 1; i <= 5; i++) callTo(32'h10 * (i + 1));
    checkOutput("overflow full", 32'(ras_full), 32'd1);
    checkOutput("overflow count", 32'(ras_count), 32'd4);
    doRet(); checkOutput("ret 1", pc_out, 32'h54);
    doRet(); checkOutput("ret 2", pc_out, 32'h44);
    doRet(); checkOutput("ret 3", pc_out, 32'h34);
    doRet(); checkOutput("ret 4", pc_out, 32'h24);
    doRet(); checkOutput("underflow pc", pc_out, RV);
    checkOutput("underflow pulse", 32'(ras_underflow), 32'd1);
    idle(); checkOutput("underflow clears", 32'(ras_underflow), 32'd0);
    checkOutput("after underflow pc", pc_out, RV + 32'd4);

    // Redirect wins over ret; stack untouched.
    jump(32'h400);
    callTo(32'h500);
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
    checkOutput("conflict pc", pc_out, 32'h300);
    checkOutput("conflict count", 32'(ras_count), 32'd1);
    doRet(); checkOutput("conflict later ret", pc_out, 32'h404);

    // Wrap at the top of the address space.
    jump(32'hFFFF_FFFC);
    checkOutput("wrap pc_seq", pc_seq, 32'h0);
    idle(); checkOutput("wrap pc", pc_out, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
    jump(32'h0000_0206);
    checkOutput("align pc", pc_out, 32'h0000_0204);
    checkOutput("align pulse", 32'(misalign), 32'd1);
    idle(); checkOutput("align clears", 32'(misalign), 32'd0);
    checkOutput("align next pc", pc_out, 32'h0000_0208);
`endif

    idle();
    idle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
